// File: rtl/instr_loader.sv
// Boot loader: streams a little-endian program image from a byte source into
// instruction memory and holds the core paused until the image is complete.
module instr_loader #(
  parameter int          ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] instr_writeaddr,
  output logic [15:0]       instr_writedata,
  output logic              instr_write,
  output logic              pause_n,
  output logic              load_done,
  output logic              load_error
);

  localparam int          TO_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic        TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA_LO,
    DATA_HI,
    DONE,
    ERROR
  } state_t;

  logic [1:0]        rst_sync_q;
  logic              rst_n_int;

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              rx_ready_q, rx_ready_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              pause_n_q, pause_n_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic              timed;
  logic              timeout_hit;
  logic [15:0]       n_new;
  logic [ADDR_W:0]   idx_inc;

  // Reset asserts asynchronously but is released only on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    lo_d     = lo_q;
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    write_d  = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    xfer        = rx_valid && rx_ready_q;
    timed       = (state_q == HDR_HI) || (state_q == DATA_LO) || (state_q == DATA_HI);
    timeout_hit = TO_EN && timed && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
    n_new       = {rx_data, n_q[7:0]};
    idx_inc     = idx_q + 1'b1;

    if (restart) begin
      state_d = HDR_LO;
      idx_d   = '0;
    end else if (timeout_hit) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        HDR_LO: if (xfer) begin
          n_d[7:0] = rx_data;
          state_d  = HDR_HI;
        end
        HDR_HI: if (xfer) begin
          n_d   = n_new;
          idx_d = '0;
          if (n_new == 16'd0)                state_d = DONE;
          else if ({1'b0, n_new} > CAPACITY) state_d = ERROR;
          else                               state_d = DATA_LO;
        end
        DATA_LO: if (xfer) begin
          lo_d    = rx_data;
          state_d = DATA_HI;
        end
        DATA_HI: if (xfer) begin
          write_d = 1'b1;
          wdata_d = {rx_data, lo_q};
          waddr_d = idx_q[ADDR_W-1:0];
          idx_d   = idx_inc;
          state_d = (17'(idx_inc) == {1'b0, n_q}) ? DONE : DATA_LO;
        end
        default: state_d = state_q;
      endcase
    end

    // The idle counter only runs while waiting mid-image with nothing happening.
    if (restart || xfer || !timed || (state_d != state_q) || !TO_EN) to_cnt_d = '0;
    else                                                              to_cnt_d = to_cnt_q + 1'b1;

    rx_ready_d = (state_d == HDR_LO) || (state_d == HDR_HI) ||
                 (state_d == DATA_LO) || (state_d == DATA_HI);
    done_d     = (state_q == DONE) && !restart;
    pause_n_d  = done_d;
    error_d    = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= HDR_LO;
      n_q        <= '0;
      lo_q       <= '0;
      idx_q      <= '0;
      to_cnt_q   <= '0;
      rx_ready_q <= 1'b1;
      write_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      pause_n_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      lo_q       <= lo_d;
      idx_q      <= idx_d;
      to_cnt_q   <= to_cnt_d;
      rx_ready_q <= rx_ready_d;
      write_q    <= write_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      pause_n_q  <= pause_n_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rx_ready        = rx_ready_q;
  assign instr_write     = write_q;
  assign instr_writeaddr = waddr_q;
  assign instr_writedata = wdata_q;
  assign pause_n         = pause_n_q;
  assign load_done       = done_q;
  assign load_error      = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: header table loop with a write
// scoreboard, plus cycle-accurate sequences for timing, timeout, restart, reset.
module tb_instr_loader;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              reset_n;
  logic              restart;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [ADDR_W-1:0] instr_writeaddr;
  logic [15:0]       instr_writedata;
  logic              instr_write;
  logic              pause_n;
  logic              load_done;
  logic              load_error;

  int compared   = 0;
  int mismatched = 0;
  int wr_count   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  wr_t exp_q[$];

  typedef struct {
    logic [7:0] n_lo;
    logic [7:0] n_hi;
    int         words;
    logic       exp_done;
    logic       exp_error;
  } vec_t;

  vec_t vecs[6];

  instr_loader #(
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .restart(restart),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .instr_writeaddr(instr_writeaddr),
    .instr_writedata(instr_writedata),
    .instr_write(instr_write),
    .pause_n(pause_n),
    .load_done(load_done),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && instr_write) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected no write",
                 instr_writeaddr, instr_writedata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(instr_writeaddr), 32'(e.addr));
        checkOutput("wr_data", 32'(instr_writedata), 32'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [ADDR_W-1:0] addr, input logic [15:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
    applyStimulus(data[7:0]);
    applyStimulus(data[15:8]);
  endtask

  task automatic pulseRestart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic checkIdleFlags(input string tag);
    checkOutput({tag, "_done"},  32'(load_done),  32'd0);
    checkOutput({tag, "_error"}, 32'(load_error), 32'd0);
    checkOutput({tag, "_pause"}, 32'(pause_n),    32'd0);
    checkOutput({tag, "_ready"}, 32'(rx_ready),   32'd1);
  endtask

  initial begin
    int base;

    vecs[0] = '{8'h00, 8'h00, 0,    1'b1, 1'b0};
    vecs[1] = '{8'h01, 8'h04, 0,    1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'h04, 1024, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 0,    1'b0, 1'b1};
    vecs[4] = '{8'h05, 8'h00, 5,    1'b1, 1'b0};
    vecs[5] = '{8'h01, 8'h00, 1,    1'b1, 1'b0};

    reset_n  = 1'b0;
    restart  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    checkIdleFlags("reset");
    checkOutput("reset_write", 32'(instr_write), 32'd0);
    checkOutput("reset_addr",  32'(instr_writeaddr), 32'd0);
    checkOutput("reset_data",  32'(instr_writedata), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Streamed three-word image with valid held high.
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    applyStimulus(8'h34);
    checkOutput("s1_nowrite_lo0", 32'(instr_write), 32'd0);
    exp_q.push_back('{10'd0, 16'h1234});
    applyStimulus(8'h12);
    checkOutput("s1_write0", 32'(instr_write), 32'd1);
    applyStimulus(8'h78);
    checkOutput("s1_nowrite_lo1", 32'(instr_write), 32'd0);
    exp_q.push_back('{10'd1, 16'h5678});
    applyStimulus(8'h56);
    checkOutput("s1_write1", 32'(instr_write), 32'd1);
    applyStimulus(8'hBC);
    exp_q.push_back('{10'd2, 16'h9ABC});
    applyStimulus(8'h9A);
    checkOutput("s1_write2", 32'(instr_write), 32'd1);
    checkOutput("s1_done_early", 32'(load_done), 32'd0);
    checkOutput("s1_pause_early", 32'(pause_n), 32'd0);
    checkOutput("s1_ready_off", 32'(rx_ready), 32'd0);
    tick();
    checkOutput("s1_done", 32'(load_done), 32'd1);
    checkOutput("s1_pause", 32'(pause_n), 32'd1);
    checkOutput("s1_write_off", 32'(instr_write), 32'd0);
    checkOutput("s1_ready_hold", 32'(rx_ready), 32'd0);

    // Header table: restart, send header and payload, compare final flags.
    for (int v = 0; v < 6; v++) begin
      pulseRestart();
      checkIdleFlags($sformatf("vec%0d_restart", v));
      base = wr_count;
      applyStimulus(vecs[v].n_lo);
      applyStimulus(vecs[v].n_hi);
      for (int w = 0; w < vecs[v].words; w++)
        sendWord(ADDR_W'(w), 16'($urandom));
      repeat (3) tick();
      checkOutput($sformatf("vec%0d_done", v),  32'(load_done),  32'(vecs[v].exp_done));
      checkOutput($sformatf("vec%0d_error", v), 32'(load_error), 32'(vecs[v].exp_error));
      checkOutput($sformatf("vec%0d_pause", v), 32'(pause_n),    32'(vecs[v].exp_done));
      checkOutput($sformatf("vec%0d_ready", v), 32'(rx_ready),   32'd0);
      checkOutput($sformatf("vec%0d_writes", v), 32'(wr_count - base), 32'(vecs[v].words));
      checkOutput($sformatf("vec%0d_pending", v), 32'(exp_q.size()), 32'd0);
    end

    // Timeout: 100 idle cycles after a data low byte.
    pulseRestart();
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    repeat (100) tick();
    checkOutput("to_not_yet", 32'(load_error), 32'd0);
    tick();
    checkOutput("to_error", 32'(load_error), 32'd1);
    checkOutput("to_pause", 32'(pause_n), 32'd0);
    checkOutput("to_ready", 32'(rx_ready), 32'd0);

    // 99 idle cycles then the byte arrives in time.
    pulseRestart();
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    repeat (99) tick();
    exp_q.push_back('{10'd0, 16'h2211});
    applyStimulus(8'h22);
    sendWord(10'd1, 16'h4433);
    tick();
    checkOutput("to99_error", 32'(load_error), 32'd0);
    checkOutput("to99_done", 32'(load_done), 32'd1);

    // Restart in the same cycle as the high data byte discards that word.
    pulseRestart();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'hAA);
    restart  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hBB;
    tick();
    restart  = 1'b0;
    rx_valid = 1'b0;
    checkOutput("rs_nowrite", 32'(instr_write), 32'd0);
    checkIdleFlags("rs");
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    sendWord(10'd0, 16'hBEEF);
    tick();
    checkOutput("rs_done", 32'(load_done), 32'd1);

    // Asynchronous reset while waiting for a high data byte.
    pulseRestart();
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    sendWord(10'd0, 16'h6655);
    applyStimulus(8'h77);
    #3;
    reset_n = 1'b0;
    #1;
    checkIdleFlags("ar");
    checkOutput("ar_write", 32'(instr_write), 32'd0);
    checkOutput("ar_data", 32'(instr_writedata), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    sendWord(10'd0, 16'hCAFE);
    sendWord(10'd1, 16'hF00D);
    tick();
    checkOutput("ar_reload_done", 32'(load_done), 32'd1);
    checkOutput("ar_reload_pause", 32'(pause_n), 32'd1);
    checkOutput("final_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
